// File: rtl/debounce_bank.sv
// N-channel push-button/switch debouncer with press, release and long-press pulses.
// Optional auto-repeat of the long-press pulse is enabled by defining DEBOUNCE_AUTOREPEAT_EN.
module debounce_bank #(
    parameter int N_CH          = 4,
    parameter int STABLE_CYCLES = 120000,
    parameter int LONG_CYCLES   = 12000000,
    parameter int REPEAT_CYCLES = 3000000,
    parameter bit ACTIVE_LOW    = 1'b1
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic [N_CH-1:0] i_in,
    output logic [N_CH-1:0] o_level,
    output logic [N_CH-1:0] o_press,
    output logic [N_CH-1:0] o_release,
    output logic [N_CH-1:0] o_long
);

    localparam int CNT_W    = $clog2(STABLE_CYCLES);
    localparam int HOLD_MAX = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
    localparam int HCNT_W   = $clog2(HOLD_MAX);

    localparam logic              IDLE      = ACTIVE_LOW ? 1'b1 : 1'b0;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [HCNT_W-1:0] LONG_LAST = HCNT_W'(LONG_CYCLES - 1);
`ifdef DEBOUNCE_AUTOREPEAT_EN
    localparam logic [HCNT_W-1:0] REPEAT_LAST = HCNT_W'(REPEAT_CYCLES - 1);
`endif

    logic [N_CH-1:0]   sync1;
    logic [N_CH-1:0]   sync2;
    logic [N_CH-1:0]   level_q;
    logic [N_CH-1:0]   press_q;
    logic [N_CH-1:0]   release_q;
    logic [N_CH-1:0]   long_q;
    logic [N_CH-1:0]   fired_q;
    logic [CNT_W-1:0]  cnt_q  [N_CH];
    logic [HCNT_W-1:0] hcnt_q [N_CH];

    logic [N_CH-1:0]   settle;
    logic [N_CH-1:0]   held;

    // settle: the synchronised input has differed for long enough and the level flips this edge
    always_comb begin
        settle = '0;
        held   = '0;
        for (int i = 0; i < N_CH; i++) begin
            settle[i] = (sync2[i] != level_q[i]) && (cnt_q[i] == CNT_LAST);
            held[i]   = (level_q[i] != IDLE);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            sync1     <= {N_CH{IDLE}};
            sync2     <= {N_CH{IDLE}};
            level_q   <= {N_CH{IDLE}};
            press_q   <= '0;
            release_q <= '0;
            long_q    <= '0;
            fired_q   <= '0;
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i]  <= '0;
                hcnt_q[i] <= '0;
            end
        end else begin
            sync1     <= i_in;
            sync2     <= sync1;
            press_q   <= '0;
            release_q <= '0;
            long_q    <= '0;
            for (int i = 0; i < N_CH; i++) begin
                if (sync2[i] == level_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (settle[i]) begin
                    cnt_q[i]     <= '0;
                    level_q[i]   <= sync2[i];
                    press_q[i]   <= (sync2[i] != IDLE);
                    release_q[i] <= (sync2[i] == IDLE);
                end else begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end

                // A settling edge in either direction restarts the hold timer, so release beats long
                if (settle[i] || !held[i]) begin
                    hcnt_q[i]  <= '0;
                    fired_q[i] <= 1'b0;
                end else if (!fired_q[i]) begin
                    if (hcnt_q[i] == LONG_LAST) begin
                        long_q[i]  <= 1'b1;
                        fired_q[i] <= 1'b1;
                        hcnt_q[i]  <= '0;
                    end else begin
                        hcnt_q[i] <= hcnt_q[i] + 1'b1;
                    end
                end
`ifdef DEBOUNCE_AUTOREPEAT_EN
                else begin
                    if (hcnt_q[i] == REPEAT_LAST) begin
                        long_q[i] <= 1'b1;
                        hcnt_q[i] <= '0;
                    end else begin
                        hcnt_q[i] <= hcnt_q[i] + 1'b1;
                    end
                end
`endif
            end
        end
    end

    assign o_level   = level_q;
    assign o_press   = press_q;
    assign o_release = release_q;
    assign o_long    = long_q;

endmodule

// File: doc/debounce_bank.md
Name: debounce_bank

Overview:
Parametrised N-channel debouncer for push-buttons and switches. It generalises the single-key, falling-edge-only debouncer. Each channel provides:
- a 2-flop synchroniser
- a stability counter
- a debounced level output
- one-cycle press and release pulses
- a one-cycle long-press pulse

It sits in the board top level between the raw KEY/SW pins and the Top controller, clocked by the 12 MHz audio clock.

Parameters:
N_CH, 4, number of independent channels
STABLE_CYCLES, 120000, consecutive identical synchronised samples required to accept a new level (10 ms at 12 MHz); must be >= 2
LONG_CYCLES, 12000000, cycles a press must be held before o_long fires (1 s); must be > STABLE_CYCLES
REPEAT_CYCLES, 3000000, auto-repeat period; used only with DEBOUNCE_AUTOREPEAT_EN
ACTIVE_LOW, 1, 1: pressed = input 0 (DE2-115 KEY); 0: pressed = input 1

Ports:
i_clk  input  1  system clock (12 MHz)
i_rst_n  input  1  synchronous active-low reset
i_in  input  N_CH  raw asynchronous button inputs
o_level  output  N_CH  debounced level, same polarity as i_in
o_press  output  N_CH  one-cycle pulse when debounced level enters pressed state
o_release  output  N_CH  one-cycle pulse when debounced level leaves pressed state
o_long  output  N_CH  one-cycle pulse on long press (and on each repeat if enabled)

Behaviour:
- Interface: one clock, i_clk. Reset i_rst_n is synchronous and active-low. All state updates on the rising edge of i_clk.
- Channels are fully independent. Simultaneous activity on several channels never interacts.
- Reset values, all channels:
  - sync flops and o_level = IDLE (all 1 if ACTIVE_LOW, else all 0)
  - stability counter = 0, hold counter = 0, fired flag = 0
  - o_press, o_release, o_long = 0
- Synchroniser: s1 <= i_in; s <= s1. The debounce logic uses only s.
- Stability counter cnt, width $clog2(STABLE_CYCLES):
  - s == o_level -> cnt <= 0
  - s != o_level and cnt == STABLE_CYCLES-1 -> o_level <= s, cnt <= 0
  - otherwise -> cnt <= cnt+1
- Latency: if i_in changes before edge k and stays stable, o_level shows the new value after edge k+STABLE_CYCLES+1.
- Glitch rejection: any sample of s equal to o_level before the count completes clears cnt. A glitch shorter than STABLE_CYCLES never changes o_level.
- Edge pulses are registered and assert in the same cycle o_level first shows the new value. They last exactly 1 cycle.
  - o_press: o_level moves from IDLE to pressed.
  - o_release: o_level moves from pressed to IDLE.
  - o_press and o_release are never high together on one channel.
- Long-press state per channel: hold counter hcnt (width $clog2(max(LONG_CYCLES, REPEAT_CYCLES))) and flag fired.
  - Cycle of o_press: hcnt <= 0, fired <= 0.
  - While pressed and !fired: hcnt increments. When hcnt == LONG_CYCLES-1: o_long pulses 1 cycle, fired <= 1, hcnt <= 0.
  - o_long therefore asserts exactly LONG_CYCLES cycles after o_press.
  - While pressed and fired, without repeat: hcnt holds and o_long stays 0.
  - When released: hcnt <= 0, fired <= 0.
  - Release in the same cycle hcnt would reach LONG_CYCLES-1: release wins and o_long does not fire.
- Reset mid-operation: everything returns to reset values on the next edge, with no pulses. A key still held after reset release yields o_press STABLE_CYCLES+2 cycles later.
- Wrap-around: no counter wraps. cnt clears on completion and hcnt is bounded by the rules above.

Optional Feature:
Macro DEBOUNCE_AUTOREPEAT_EN.
- Defined: after the first o_long, while still pressed, hcnt counts again. o_long pulses each time hcnt == REPEAT_CYCLES-1, and hcnt then reloads to 0. Repeats continue every REPEAT_CYCLES cycles until release. Release clears hcnt and the fired flag, with no pulse.
- Undefined: o_long fires at most once per press. REPEAT_CYCLES is ignored and the repeat logic is not synthesised.

Test Plan:
(Bench parameters: N_CH=4, STABLE_CYCLES=4, LONG_CYCLES=20, REPEAT_CYCLES=8, ACTIVE_LOW=1.)
1. Reset, all i_in=1 -> o_level=4'b1111 and all pulses 0 for 50 cycles.
2. i_in[0] driven to 0 before edge k and held -> o_level[0]=0 and o_press[0]=1 for one cycle after edge k+5; release similarly -> one-cycle o_release[0].
3. i_in[1] glitches to 0 for 3 cycles, repeated 5 times with 1-cycle gaps -> o_level[1] stays 1, no pulses.
4. i_in[2] held at 0 for 40 cycles -> o_long[2] exactly 20 cycles after o_press[2], once only. With DEBOUNCE_AUTOREPEAT_EN: further o_long[2] pulses at +8 and +16 after that.
5. i_in[0] and i_in[3] pressed on the same cycle -> o_press[0] and o_press[3] asserted on the same cycle; channels 1 and 2 unaffected.
6. i_rst_n low for 1 cycle while channel 2 is held with hcnt=10 -> all outputs to reset values. o_press[2] reappears 6 cycles after reset deasserts, and o_long[2] reappears 20 cycles after that.
